instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Fetch stage between program_counter and the decoder. Reads instructions from a synchronous ROM at pc_out and buffers them with their addresses in a small prefetch FIFO. Presents them to the decoder over a valid/ready handshake. Drives the PC's pc_load/pc_new pair: it holds the PC when the buffer cannot accept more, and it redirects the PC on branches/jumps.

Parameters:
ADDR_W, 16, PC/ROM address width (matches program_counter)
INSTR_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pc_out  in  ADDR_W  current PC from program_counter
pc_load  out  1  PC load strobe (hold or redirect)
pc_new  out  ADDR_W  value the PC loads when pc_load=1
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_data  in  INSTR_W  ROM read data, valid the cycle after rom_en=1
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_target  in  ADDR_W  branch/jump target
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decoder accepts head
instr_data  out  INSTR_W  head instruction
instr_pc  out  ADDR_W  address of head instruction
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst_n=0, async): FIFO empty, fifo_count=0, inflight=0, instr_valid=0, instr_data=0, instr_pc=0. The comb outputs rom_en/pc_load are forced to 0 while rst_n=0.
- rom_addr = pc_out (combinational).
- issue = !redirect_valid && (fifo_count + inflight < DEPTH). Pops in the same cycle are not credited, which keeps the credit check conservative.
- rom_en = issue.
- PC control, in priority order:
  - redirect_valid=1 -> pc_load=1, pc_new=redirect_target.
  - else issue=0 -> pc_load=1, pc_new=pc_out (hold).
  - else pc_load=0, so the PC increments itself.
- In-flight register: on issue, set inflight=1 and capture inflight_pc=pc_out. Otherwise clear inflight.
- Capture: if inflight=1 and no redirect this cycle, push {rom_data, inflight_pc} at the clock edge.
- Latency: address issued in cycle N -> instr_valid=1 with that instruction in cycle N+2.
- FIFO:
  - Circular buffer with DEPTH entries.
  - Head registered onto instr_data/instr_pc; instr_valid = (fifo_count != 0).
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle are both performed and fifo_count is unchanged.
  - Push when full cannot occur by construction of the credit check; an assertion flags it.
- Redirect (priority over everything):
  - At the edge ending the redirect cycle, the FIFO is flushed (count=0, pointers reset) and inflight is cleared.
  - Any same-cycle pop or push is discarded.
  - The next cycle pc_out=redirect_target and issue resumes.
  - The first redirected instruction reaches instr_valid 3 cycles after the redirect cycle (N+3).
- Wrap-around: the PC wraps 0xFFFF->0x0000 on its own; instr_pc is captured verbatim.
- No ROM error handling; rom_data is trusted.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty and inflight=1 (no redirect), instr_valid=1 comb with instr_data=rom_data and instr_pc=inflight_pc. This cuts latency to N+1.
  - If instr_ready=1, the word is consumed and not pushed.
  - Otherwise it is pushed as normal.
- Undefined: head is always from FIFO registers, latency N+2, and instr_valid is purely registered.

Test Plan:
- Reset release, instr_ready=1, rom_data=addr^16'hA500:
  - instr_valid first high in cycle 2 with instr_pc=0x0000, instr_data=0xA500.
  - Then consecutive pcs 0x0001, 0x0002, … every cycle; pc_load stays 0.
- instr_ready=0 from reset:
  - fifo_count reaches 4 with instr_pc 0..3 queued.
  - Afterwards pc_load=1, pc_new=pc_out=0x0004, rom_en=0 every cycle.
  - Raise ready: entries drain in order 0..3 and fetch resumes at 0x0004.
- Redirect pulse to 0x0100 with 2 entries queued and one read in flight:
  - Redirect cycle: pc_load=1, pc_new=0x0100.
  - Next cycle fifo_count=0 and instr_valid=0; no stale instr_pc is ever presented.
  - Next valid instr_pc=0x0100.
- Redirect to 0xFFFE, ready=1: instr_pc sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert rst_n=0 mid-stream with fifo_count=3: outputs clear immediately (async); after release, fetch restarts at 0x0000.
- FETCH_BYPASS_EN defined, ready=1 from reset: first instr_valid in cycle 1 with instr_pc=0x0000, and fifo_count stays 0 throughout.

Source files
------------

// File: rtl/instr_fetch.sv
// Fetch stage: issues ROM reads at pc_out, buffers {instr, pc} in a prefetch FIFO and controls PC hold/redirect.
// Optional FETCH_BYPASS_EN presents an in-flight ROM word directly when the FIFO is empty.
module instr_fetch #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        pc_out,
    output logic                     pc_load,
    output logic [ADDR_W-1:0]        pc_new,
    output logic                     rom_en,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [INSTR_W-1:0]       rom_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_target,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_W-1:0] mem_data [DEPTH];
    logic [ADDR_W-1:0]  mem_pc   [DEPTH];

    logic [PW-1:0]      rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [INSTR_W-1:0] head_data, head_data_nxt;
    logic [ADDR_W-1:0]  head_pc, head_pc_nxt;

    logic credit, issue, push, pop, fifo_valid;

    // Credit ignores same-cycle pops so a word in flight always has a free slot.
    always_comb begin
        credit = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);
        issue  = !redirect_valid && credit;
    end

    assign rom_addr   = pc_out;
    assign rom_en     = rst_n && issue;
    assign pc_load    = rst_n && (redirect_valid || !issue);
    assign pc_new     = redirect_valid ? redirect_target : pc_out;
    assign fifo_count = count;
    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid && instr_ready;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    always_comb begin
        bypass      = !fifo_valid && inflight && !redirect_valid;
        push        = inflight && !redirect_valid && !(bypass && instr_ready);
        instr_valid = fifo_valid || bypass;
        instr_data  = bypass ? rom_data    : head_data;
        instr_pc    = bypass ? inflight_pc : head_pc;
    end
`else
    always_comb begin
        push        = inflight && !redirect_valid;
        instr_valid = fifo_valid;
        instr_data  = head_data;
        instr_pc    = head_pc;
    end
`endif

    always_comb begin
        rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        // Head register tracks the next FIFO head; a push into an empty queue bypasses the array.
        head_data_nxt = '0;
        head_pc_nxt   = '0;
        if (count_nxt != '0) begin
            if (push && (rd_ptr_nxt == wr_ptr)) begin
                head_data_nxt = rom_data;
                head_pc_nxt   = inflight_pc;
            end else begin
                head_data_nxt = mem_data[rd_ptr_nxt];
                head_pc_nxt   = mem_pc[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head_data   <= '0;
            head_pc     <= '0;
        end else if (redirect_valid) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= 1'b0;
            head_data <= '0;
            head_pc   <= '0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            count     <= count_nxt;
            head_data <= head_data_nxt;
            head_pc   <= head_pc_nxt;
            inflight  <= issue;
            if (issue) begin
                inflight_pc <= pc_out;
            end
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural program counter and synchronous ROM (data = addr ^ 16'hA500).
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_out;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic [2:0]  fifo_count;

    int tests    = 0;
    int failures = 0;

    instr_fetch #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_out          (pc_out),
        .pc_load         (pc_load),
        .pc_new          (pc_new),
        .rom_en          (rom_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_data      (instr_data),
        .instr_pc        (instr_pc),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    // Program counter: loads pc_new on pc_load, otherwise increments (wraps naturally).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc_out <= 16'h0000;
        else if (pc_load) pc_out <= pc_new;
        else              pc_out <= pc_out + 16'h0001;
    end

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_addr ^ 16'hA500;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_count"}, 32'(fifo_count),  32'd0);
        check({tag, "_data"},  32'(instr_data),  32'd0);
        check({tag, "_pc"},    32'(instr_pc),    32'd0);
        check({tag, "_romen"}, 32'(rom_en),      32'd0);
        check({tag, "_pcld"},  32'(pc_load),     32'd0);
    endtask

    initial begin
        logic [15:0] e;
        rst_n           = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");

`ifdef FETCH_BYPASS_EN
        rst_n = 1'b1;
        #1;
        check("byp_c0_valid", 32'(instr_valid), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            #1;
            e = 16'(k - 1);
            check("byp_valid", 32'(instr_valid), 32'd1);
            check("byp_pc",    32'(instr_pc),    32'(e));
            check("byp_data",  32'(instr_data),  32'(e ^ 16'hA500));
            check("byp_count", 32'(fifo_count),  32'd0);
        end
`else
        // Streaming from reset with ready=1
        rst_n = 1'b1;
        #1;
        check("s_c0_romen", 32'(rom_en),      32'd1);
        check("s_c0_pcld",  32'(pc_load),     32'd0);
        check("s_c0_valid", 32'(instr_valid), 32'd0);
        check("s_c0_addr",  32'(rom_addr),    32'h0000);
        cyc();
        #1;
        check("s_c1_valid", 32'(instr_valid), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            cyc();
            #1;
            e = 16'(k - 2);
            check("s_valid", 32'(instr_valid), 32'd1);
            check("s_pc",    32'(instr_pc),    32'(e));
            check("s_data",  32'(instr_data),  32'(e ^ 16'hA500));
            check("s_pcld",  32'(pc_load),     32'd0);
            check("s_count", 32'(fifo_count),  32'd1);
        end

        // Back-pressure from reset: FIFO fills with 0..3, PC held at 4
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            cyc();
            #1;
            if (k == 3) check("bp_c3_count", 32'(fifo_count), 32'd2);
            if (k >= 4) begin
                check("bp_pcld",  32'(pc_load), 32'd1);
                check("bp_pcnew", 32'(pc_new),  32'h0004);
                check("bp_romen", 32'(rom_en),  32'd0);
            end
            if (k >= 5) begin
                check("bp_count", 32'(fifo_count), 32'd4);
                check("bp_head",  32'(instr_pc),   32'h0000);
            end
        end
        for (int i = 0; i <= 5; i++) begin
            cyc();
            instr_ready = 1'b1;
            #1;
            e = 16'(i);
            check("dr_valid", 32'(instr_valid), 32'd1);
            check("dr_pc",    32'(instr_pc),    32'(e));
            check("dr_data",  32'(instr_data),  32'(e ^ 16'hA500));
            if (i == 0) check("dr_c8_romen", 32'(rom_en), 32'd0);
            if (i == 1) begin
                check("dr_c9_romen", 32'(rom_en),  32'd1);
                check("dr_c9_addr",  32'(rom_addr), 32'h0004);
            end
            if (i == 5) check("dr_c13_count", 32'(fifo_count), 32'd2);
        end

        // Redirect to 0x0100 with two queued and one in flight
        cyc();
        redirect_valid  = 1'b1;
        redirect_target = 16'h0100;
        #1;
        check("rd_pcld",  32'(pc_load), 32'd1);
        check("rd_pcnew", 32'(pc_new),  32'h0100);
        check("rd_romen", 32'(rom_en),  32'd0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("rd_n1_count", 32'(fifo_count),  32'd0);
        check("rd_n1_valid", 32'(instr_valid), 32'd0);
        check("rd_n1_addr",  32'(rom_addr),    32'h0100);
        cyc();
        #1;
        check("rd_n2_valid", 32'(instr_valid), 32'd0);
        cyc();
        #1;
        check("rd_n3_valid", 32'(instr_valid), 32'd1);
        check("rd_n3_pc",    32'(instr_pc),    32'h0100);
        check("rd_n3_data",  32'(instr_data),  32'hA400);

        // Redirect near the top of the address space: sequence wraps
        cyc();
        redirect_valid  = 1'b1;
        redirect_target = 16'hFFFE;
        #1;
        check("wr_pcnew", 32'(pc_new), 32'hFFFE);
        cyc();
        redirect_valid = 1'b0;
        #1;
        cyc();
        #1;
        check("wr_n2_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i <= 3; i++) begin
            cyc();
            #1;
            e = 16'hFFFE + 16'(i);
            check("wr_valid", 32'(instr_valid), 32'd1);
            check("wr_pc",    32'(instr_pc),    32'(e));
            check("wr_data",  32'(instr_data),  32'(e ^ 16'hA500));
        end

        // Asynchronous reset mid-stream with three entries queued
        cyc();
        instr_ready = 1'b0;
        cyc();
        cyc();
        #1;
        check("ar_count_pre", 32'(fifo_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("ar");
        cyc();
        cyc();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("ar_c0_addr",  32'(rom_addr), 32'h0000);
        check("ar_c0_romen", 32'(rom_en),   32'd1);
        cyc();
        cyc();
        #1;
        check("ar_c2_valid", 32'(instr_valid), 32'd1);
        check("ar_c2_pc",    32'(instr_pc),    32'h0000);
        cyc();
        #1;
        check("ar_c3_pc",    32'(instr_pc),    32'h0001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
